// File: rtl/sel_encoder_pkg.sv
// Shared constants and state encoding for the select-code priority encoder.
package sel_encoder_pkg;

  localparam int unsigned SEL_ENC_N_REQ = 4;
  localparam int unsigned SEL_ENC_IDX_W = 2;

  typedef enum logic [0:0] {
    SEL_ENC_IDLE = 1'b0,
    SEL_ENC_EMIT = 1'b1
  } sel_enc_state_e;

endpackage

// File: rtl/msb_index.sv
// Combinational priority scan: index of the highest set mask bit, plus single/none flags.
module msb_index
  import sel_encoder_pkg::*;
#(
  parameter int unsigned N_REQ = SEL_ENC_N_REQ,
  parameter int unsigned IDX_W = SEL_ENC_IDX_W
) (
  input  logic [N_REQ-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             single_o,
  output logic             none_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign none_o   = (mask_i == '0);
  assign single_o = !none_o && ((mask_i & (mask_i - N_REQ'(1))) == '0);

endmodule

// File: rtl/sel_encoder.sv
// Sequential MSB-first priority encoder feeding the 2-bit select decoder.
// Optional macro SEL_ENC_XCHECK_EN drops request vectors carrying X/Z bits (simulation only).
module sel_encoder
  import sel_encoder_pkg::*;
#(
  parameter int unsigned N_REQ = SEL_ENC_N_REQ,
  parameter int unsigned IDX_W = SEL_ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_REQ-1:0] req_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_sel,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  sel_enc_state_e   state_q, state_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] nx_idx;
  logic             nx_single;
  logic             nx_none;
  logic             vec_drop;

`ifdef SEL_ENC_XCHECK_EN
  assign vec_drop = (req_vec == '0) || ((^req_vec) === 1'bx);
`else
  assign vec_drop = (req_vec == '0);
`endif

  assign req_ready = (state_q == SEL_ENC_IDLE) && !rst;

  // Outputs are precomputed from the next mask so they are valid the cycle after the edge.
  msb_index #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_msb_index (
    .mask_i   (mask_d),
    .idx_o    (nx_idx),
    .single_o (nx_single),
    .none_o   (nx_none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEL_ENC_IDLE;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    err_d   = 1'b0;

    case (state_q)
      SEL_ENC_IDLE: begin
        if (req_valid && req_ready) begin
          if (vec_drop) begin
            err_d = 1'b1;
          end else begin
            mask_d  = req_vec;
            state_d = SEL_ENC_EMIT;
          end
        end
      end
      SEL_ENC_EMIT: begin
        if (out_valid_q && out_ready) begin
          mask_d = mask_q & ~(N_REQ'(1) << out_sel_q);
          if (out_last_q) state_d = SEL_ENC_IDLE;
        end
      end
      default: state_d = SEL_ENC_IDLE;
    endcase

    out_valid_d = (state_d == SEL_ENC_EMIT) && !nx_none;
    out_sel_d   = nx_idx;
    out_last_d  = (state_d == SEL_ENC_EMIT) && nx_single;
    busy_d      = (state_d == SEL_ENC_EMIT);
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sel_encoder.sv
// Directed bench for sel_encoder with a scoreboard of expected select codes.
module tb_sel_encoder;

  typedef struct packed {
    logic [1:0] sel;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sel;
  logic       out_last;
  logic       busy;
  logic       err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b1;
  bit   stalled = 1'b0;
  exp_t held;

  sel_encoder #(.N_REQ(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one code per set bit, MSB first, last on the final one.
  task automatic push_vec(input logic [3:0] v);
    int   cnt;
    exp_t e;
    cnt = 0;
    for (int i = 0; i < 4; i++) if (v[i]) cnt++;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin
        e.sel  = 2'(i);
        e.last = (cnt == 1);
        exp_q.push_back(e);
        cnt--;
      end
    end
  endtask

  // Output monitor: compares each transfer against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst || !mon_en) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        chk("hold_sel", 32'(out_sel), 32'(held.sel));
        chk("hold_last", 32'(out_last), 32'(held.last));
      end
      if (out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_code", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sel", 32'(out_sel), 32'(e.sel));
          chk("sb_last", 32'(out_last), 32'(e.last));
        end
      end else begin
        stalled   = 1'b1;
        held.sel  = out_sel;
        held.last = out_last;
      end
    end
  end

  initial begin
    logic [5:0] pat;
    logic [3:0] xv;
    int         budget;

    rst = 1'b1; req_valid = 1'b0; req_vec = 4'b0000; out_ready = 1'b0;

    // Reset held for two cycles.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);

    // MSB-first stream of 4'b1010.
    out_ready = 1'b1; req_valid = 1'b1; req_vec = 4'b1010;
    push_vec(4'b1010);
    tick();
    req_valid = 1'b0; req_vec = 4'b0101;
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_sel0", 32'(out_sel), 32'd3);
    chk("s1_last0", 32'(out_last), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("s1_sel1", 32'(out_sel), 32'd1);
    chk("s1_last1", 32'(out_last), 32'd1);
    tick();
    chk("s1_busy_after", 32'(busy), 32'd0);
    chk("s1_valid_after", 32'(out_valid), 32'd0);
    chk("s1_ready_after", 32'(req_ready), 32'd1);

    // Back-pressure on 4'b1111.
    pat = 6'b111001;
    req_valid = 1'b1; req_vec = 4'b1111;
    push_vec(4'b1111);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      tick();
    end
    chk("bp_busy_after", 32'(busy), 32'd0);
    chk("bp_ready_after", 32'(req_ready), 32'd1);
    out_ready = 1'b1;

    // Zero vector drops with a one-cycle err pulse.
    req_valid = 1'b1; req_vec = 4'b0000;
    tick();
    req_valid = 1'b0;
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_ready", 32'(req_ready), 32'd1);
    tick();
    chk("zero_err_clear", 32'(err), 32'd0);
    chk("zero_valid_after", 32'(out_valid), 32'd0);

    // Single bit gives a single last beat.
    req_valid = 1'b1; req_vec = 4'b0001;
    push_vec(4'b0001);
    tick();
    req_valid = 1'b0;
    chk("single_sel", 32'(out_sel), 32'd0);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_valid", 32'(out_valid), 32'd1);
    tick();
    chk("single_busy_after", 32'(busy), 32'd0);

    // Reset after the first transfer of 4'b1110; a handshake during reset is ignored.
    req_valid = 1'b1; req_vec = 4'b1110;
    push_vec(4'b1110);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1; req_valid = 1'b1; req_vec = 4'b0000;
    exp_q.delete();
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_err", 32'(err), 32'd0);
    end

    // Request vector carrying an unknown bit.
    mon_en = 1'b0;
    xv = 4'b1x00;
    req_valid = 1'b1; req_vec = xv;
    tick();
    req_valid = 1'b0;
`ifdef SEL_ENC_XCHECK_EN
    chk("x_err", 32'(err), 32'd1);
    chk("x_valid", 32'(out_valid), 32'd0);
`else
    chk("x_valid", 32'(out_valid), 32'd1);
    chk("x_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("x_cleanup_valid", 32'(out_valid), 32'd0);

    // Scoreboard must be drained within a bounded wait.
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
